remote_cmd_link: RTL and testbench
==================================

Name: remote_cmd_link

Overview:
- Host-side serial command link for the knight robot. Turns a 16-bit command into two UART bytes (8N1, high byte first) and reports when the second byte has been sent.
- Independently receives single-byte responses from the robot and presents them with a ready flag.
- Sits in the test harness and remote host, wired TX->robot RX and robot TX->RX.

Parameters:
- BAUD_DIV, 434, clock cycles per UART bit (434 = 50 MHz / 115200); legal range 8..4095.
- TIMEOUT_CYCLES, 5000000, response timeout window (used only with RESP_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- cmd  in  16  command word; captured when snd_cmd is accepted.
- snd_cmd  in  1  single-cycle request to transmit cmd.
- cmd_snt  out  1  one-cycle pulse when both bytes have left the TX line.
- TX  out  1  UART serial out; idles high.
- RX  in  1  UART serial in; asynchronous to clk.
- resp  out  8  last valid received byte.
- resp_rdy  out  1  level flag: a new byte is available in resp.

Behaviour:
- Reset values: TX=1, cmd_snt=0, resp=8'h00, resp_rdy=0, FSM=IDLE, all counters 0.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly BAUD_DIV cycles.
- Transmit FSM states:
  - IDLE: on snd_cmd=1, latch cmd into a 16-bit holding register and go to SEND_HI.
  - SEND_HI: transmit cmd[15:8]. When its stop bit completes, go to SEND_LO.
  - SEND_LO: transmit cmd[7:0]; its start bit begins the cycle after the high byte's stop bit ends (no idle gap). When its stop bit completes, go to DONE.
  - DONE: drive cmd_snt=1 for exactly one cycle, then return to IDLE.
- Timing: TX falls to the start bit on the cycle after snd_cmd is sampled. cmd_snt pulses 20*BAUD_DIV+1 (±1) cycles after the snd_cmd edge.
- snd_cmd while not IDLE is ignored; the holding register is not overwritten. Changes to cmd after acceptance have no effect.
- Back-to-back commands: snd_cmd in the same cycle DONE returns to IDLE is not accepted. It is accepted from the following cycle.
- Receiver:
  - RX passes through a 2-flop synchronizer.
  - A falling edge while idle starts a frame; the line is sampled at BAUD_DIV/2 into the start bit.
  - If the start-bit sample is 1: false start; return to idle, no output change.
  - Data bits are sampled every BAUD_DIV cycles thereafter, mid-bit, shifting LSB first.
  - Stop-bit sample is 1: load resp and set resp_rdy the cycle after that sample.
  - Stop-bit sample is 0 (framing error): discard the byte; resp and resp_rdy unchanged.
- resp_rdy clears when snd_cmd is accepted or when a new start bit is validated. Set and clear in the same cycle: set wins.
- Receiver and transmitter are independent; full duplex is allowed.
- rst asserted mid-frame aborts both paths immediately: TX=1, all outputs to reset values. No partial byte is ever presented.

Optional Feature:
- Macro RESP_TIMEOUT_EN.
- Defined:
  - Adds output port resp_tmo (1 bit, reset 0) and a counter started at the cmd_snt pulse.
  - If no valid byte is received within TIMEOUT_CYCLES, resp_tmo is set; it is held until the next accepted snd_cmd.
  - A byte received after the timeout still sets resp_rdy.
- Undefined: no resp_tmo port, no counter; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 5 cycles with BAUD_DIV=16 -> TX=1, cmd_snt=0, resp_rdy=0, resp=0. Assert rst mid-TX-frame -> TX returns to 1 in the same cycle.
- Send: cmd=16'hA53C, pulse snd_cmd, BAUD_DIV=16 -> TX shows 0,00111100... wait, high byte first: 0,1010 0101 reversed (LSB first: 1,0,1,0,0,1,0,1),1, then 0,(0,0,1,1,1,1,0,0),1 -> cmd_snt pulses once at cycle 321±1.
- Busy ignore: second snd_cmd with cmd=16'h1234 at cycle 50 of the first send -> transmitted bytes remain A5,3C; only one cmd_snt pulse.
- Loopback TX->RX, send 16'h00FF -> resp_rdy set after the first byte with resp=8'h00, then resp=8'hFF. A subsequent snd_cmd clears resp_rdy.
- RX robustness: 3-cycle low glitch on RX -> no resp_rdy. Frame 8'h5A with stop bit 0 -> resp_rdy stays 0, resp unchanged.
- RESP_TIMEOUT_EN with TIMEOUT_CYCLES=1000: send a command with no reply -> resp_tmo=1 at 1000±1 cycles after cmd_snt. A reply inside the window -> resp_tmo stays 0.

Source files
------------

// File: rtl/remote_cmd_link.sv
// remote_cmd_link
//   Host-side UART command link. A 16-bit command is sent as two 8N1 frames,
//   high byte first, with no idle gap between them. cmd_snt pulses once after
//   the low byte's stop bit. An independent receiver presents single response
//   bytes on resp and raises the resp_rdy level flag.
//
//   Optional feature, selected by macro RESP_TIMEOUT_EN:
//     adds resp_tmo, set when no valid byte arrives within TIMEOUT_CYCLES of
//     the cmd_snt pulse. It is held until the next accepted snd_cmd.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   cmd        command word, captured when snd_cmd is accepted
//   snd_cmd    single-cycle transmit request (honoured only while idle)
//   cmd_snt    one-cycle pulse after both bytes have left TX
//   TX         UART serial out, idles high
//   RX         UART serial in, asynchronous to clk
//   resp       last valid received byte
//   resp_rdy   level flag: a new byte is available in resp
//   resp_tmo   response timeout flag (RESP_TIMEOUT_EN only)
//   o_tx_state transmit FSM state (debug)
//   o_rx_state receive FSM state (debug)
//
// Handshake: snd_cmd is a request, not a valid/ready pair. It is accepted
// only in the cycle the transmit FSM is IDLE. A request seen in any other
// cycle is dropped, and the holding register keeps the command in flight.
module remote_cmd_link #(
  parameter int BAUD_DIV       = 434,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
`ifdef RESP_TIMEOUT_EN
  output logic        resp_tmo,
`endif
  output logic [1:0]  o_tx_state,
  output logic [1:0]  o_rx_state
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

  // ---------------- transmitter ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_SEND_HI, TX_SEND_LO, TX_DONE} tx_state_t;

  tx_state_t   r_tx_state, w_tx_state_nxt;
  logic [15:0] r_hold, w_hold_nxt;
  logic [11:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [3:0]  r_tx_bit, w_tx_bit_nxt;
  logic        r_tx, w_tx_nxt;
  logic        r_cmd_snt;
  logic        w_accept;
  logic [7:0]  w_tx_byte;
  logic [9:0]  w_frame;

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_hold_nxt     = r_hold;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_accept       = 1'b0;
    w_tx_byte      = 8'h00;
    w_frame        = 10'h3ff;
    w_tx_nxt       = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        if (snd_cmd) begin
          w_accept       = 1'b1;
          w_hold_nxt     = cmd;
          w_tx_state_nxt = TX_SEND_HI;
          w_tx_cnt_nxt   = 12'd0;
          w_tx_bit_nxt   = 4'd0;
        end
      end
      TX_SEND_HI, TX_SEND_LO: begin
        if (r_tx_cnt == BAUD_LAST) begin
          w_tx_cnt_nxt = 12'd0;
          if (r_tx_bit == 4'd9) begin
            // Low byte's start bit follows the high byte's stop bit directly.
            w_tx_bit_nxt   = 4'd0;
            w_tx_state_nxt = (r_tx_state == TX_SEND_HI) ? TX_SEND_LO : TX_DONE;
          end else begin
            w_tx_bit_nxt = r_tx_bit + 4'd1;
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 12'd1;
        end
      end
      TX_DONE: w_tx_state_nxt = TX_IDLE;
      default: w_tx_state_nxt = TX_IDLE;
    endcase
    // TX is registered from the next-state view so the line never glitches.
    w_tx_byte = (w_tx_state_nxt == TX_SEND_HI) ? w_hold_nxt[15:8] : w_hold_nxt[7:0];
    w_frame   = {1'b1, w_tx_byte, 1'b0};
    if (w_tx_state_nxt == TX_SEND_HI || w_tx_state_nxt == TX_SEND_LO)
      w_tx_nxt = w_frame[w_tx_bit_nxt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_hold     <= 16'h0000;
      r_tx_cnt   <= 12'd0;
      r_tx_bit   <= 4'd0;
      r_tx       <= 1'b1;
      r_cmd_snt  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_hold     <= w_hold_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx       <= w_tx_nxt;
      r_cmd_snt  <= (r_tx_state == TX_DONE);
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   r_rx_state, w_rx_state_nxt;
  logic        r_rx_meta, r_rx_sync, r_rx_prev;
  logic [11:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]  r_rx_bit, w_rx_bit_nxt;
  logic [7:0]  r_rx_shift, w_rx_shift_nxt;
  logic [7:0]  r_resp;
  logic        r_resp_rdy;
  logic        w_rx_start_ok;
  logic        w_rx_good;

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_start_ok  = 1'b0;
    w_rx_good      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = 12'd0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt = 12'd0;
          if (!r_rx_sync) begin
            w_rx_start_ok  = 1'b1;
            w_rx_bit_nxt   = 3'd0;
            w_rx_state_nxt = RX_DATA;
          end else begin
            w_rx_state_nxt = RX_IDLE;  // glitch, not a start bit
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 12'd1;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BAUD_LAST) begin
          w_rx_cnt_nxt   = 12'd0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
          else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 12'd1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BAUD_LAST) begin
          w_rx_cnt_nxt   = 12'd0;
          w_rx_state_nxt = RX_IDLE;
          w_rx_good      = r_rx_sync;  // low stop bit: framing error, drop byte
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 12'd1;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Synchronizer resets to the idle line level so reset release is not
      // mistaken for a start edge.
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= 12'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_resp     <= 8'h00;
      r_resp_rdy <= 1'b0;
    end else begin
      r_rx_meta  <= RX;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      if (w_rx_good) begin
        r_resp     <= r_rx_shift;
        r_resp_rdy <= 1'b1;  // set wins over a simultaneous clear
      end else if (w_accept || w_rx_start_ok) begin
        r_resp_rdy <= 1'b0;
      end
    end
  end

`ifdef RESP_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] r_tmo_cnt;
  logic        r_tmo_active;
  logic        r_resp_tmo;

  // The cmd_snt cycle counts as the first cycle of the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt    <= 32'd0;
      r_tmo_active <= 1'b0;
      r_resp_tmo   <= 1'b0;
    end else if (w_accept) begin
      r_tmo_active <= 1'b0;
      r_resp_tmo   <= 1'b0;
    end else if (r_cmd_snt) begin
      r_tmo_cnt    <= 32'd1;
      r_tmo_active <= 1'b1;
    end else if (w_rx_good) begin
      r_tmo_active <= 1'b0;
    end else if (r_tmo_active) begin
      if (r_tmo_cnt >= TMO_LAST) begin
        r_resp_tmo   <= 1'b1;
        r_tmo_active <= 1'b0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 32'd1;
      end
    end
  end

  assign resp_tmo = r_resp_tmo;
`endif

  assign TX         = r_tx;
  assign cmd_snt    = r_cmd_snt;
  assign resp       = r_resp;
  assign resp_rdy   = r_resp_rdy;
  assign o_tx_state = r_tx_state;
  assign o_rx_state = r_rx_state;

endmodule

// File: tb/tb_remote_cmd_link.sv
module tb_remote_cmd_link;
  localparam int B = 16;
  localparam int T = 1000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd = 16'h0000;
  logic        snd_cmd = 1'b0;
  logic        cmd_snt, TX, RX, resp_rdy;
  logic [7:0]  resp;
  logic [1:0]  tx_st, rx_st;
`ifdef RESP_TIMEOUT_EN
  logic        resp_tmo;
`endif
  logic        loop_en = 1'b0;
  logic        rx_drv  = 1'b1;

  assign RX = loop_en ? TX : rx_drv;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  remote_cmd_link #(.BAUD_DIV(B), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt),
    .TX(TX), .RX(RX), .resp(resp), .resp_rdy(resp_rdy),
`ifdef RESP_TIMEOUT_EN
    .resp_tmo(resp_tmo),
`endif
    .o_tx_state(tx_st), .o_rx_state(rx_st)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_resp_q[$];
  int         exp_snt_q[$];
  int         n_vec  = 0;
  int         n_fail = 0;
  int         tx_free = 0;       // first edge at which a new command is accepted
  logic [7:0] model_resp = 8'h00;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- drivers ----------------
  // Reference: a command occupies the link for 20 bit times plus the done
  // cycle, and a request is honoured only once that whole window has passed.
  task automatic send_cmd(input logic [15:0] data);
    int a;
    @(negedge clk);
    cmd     = data;
    snd_cmd = 1'b1;
    a       = cyc + 1;
    if (a >= tx_free) begin
      exp_tx_q.push_back(data[15:8]);
      exp_tx_q.push_back(data[7:0]);
      exp_snt_q.push_back(a + 20 * B + 1);
      if (loop_en) begin
        exp_resp_q.push_back(data[15:8]);
        exp_resp_q.push_back(data[7:0]);
        model_resp = data[7:0];
      end
      tx_free = a + 20 * B + 2;
    end
    @(negedge clk);
    snd_cmd = 1'b0;
    cmd     = 16'($urandom);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_resp_q.push_back(b);
      model_resp = b;
    end
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (B) @(negedge clk);
    end
    rx_drv = stop;
    repeat (B) @(negedge clk);
    rx_drv = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((exp_tx_q.size() + exp_resp_q.size() + exp_snt_q.size()) != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq(name, exp_tx_q.size() + exp_resp_q.size() + exp_snt_q.size(), 0);
  endtask

  task automatic wait_snt(output int at);
    int k = 0;
    while (cmd_snt !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    at = cyc;
  endtask

  // ---------------- monitors ----------------
  // TX line decoder: independent UART receiver sampling mid-bit.
  initial begin
    logic [7:0] b;
    logic       stop;
    forever begin
      @(negedge clk);
      if (TX === 1'b0 && rst === 1'b0) begin
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = TX;
        end
        repeat (B) @(negedge clk);
        stop = TX;
        if (exp_tx_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL tx_extra: byte %02h sent, none expected", b);
        end else begin
          check_eq("tx_byte", b, exp_tx_q.pop_front());
        end
        check_eq("tx_stop", stop, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (cmd_snt === 1'b1) begin
      if (exp_snt_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL cmd_snt_extra: pulse at cycle %0d, none expected", cyc);
      end else begin
        int e;
        e = exp_snt_q.pop_front();
        check_rng("cmd_snt_time", cyc, e - 1, e + 1);
      end
    end
  end

  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    if (resp_rdy === 1'b1 && prev_rdy !== 1'b1) begin
      if (exp_resp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL resp_extra: resp_rdy with %02h, none expected", resp);
      end else begin
        check_eq("resp_byte", resp, exp_resp_q.pop_front());
      end
    end
    prev_rdy = resp_rdy;
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    logic seen;

    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_tx", TX, 1);
    check_eq("rst_cmd_snt", cmd_snt, 0);
    check_eq("rst_resp_rdy", resp_rdy, 0);
    check_eq("rst_resp", resp, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed send with a busy-time request that must be dropped.
    loop_en = 1'b1;
    send_cmd(16'hA53C);
    repeat (48) @(negedge clk);
    send_cmd(16'h1234);
    drain("a53c_pending", 2000);

    // Loopback 00FF, then a new command clears resp_rdy.
    send_cmd(16'h00FF);
    drain("00ff_pending", 2000);
    check_eq("rdy_after_loop", resp_rdy, 1);
    check_eq("resp_after_loop", resp, 8'hFF);
    send_cmd(16'($urandom));
    check_eq("rdy_clr_on_send", resp_rdy, 0);
    drain("clr_pending", 2000);

    // Random commands with random gaps; short gaps land while busy.
    for (int n = 0; n < 16; n++) begin
      send_cmd(16'($urandom));
      repeat ($urandom_range(0, 400)) @(negedge clk);
    end
    drain("rand_pending", 4000);

    // Receiver driven by the bench, with a concurrent transmit.
    loop_en = 1'b0;
    fork
      send_cmd(16'($urandom));
      for (int n = 0; n < 12; n++)
        rx_frame(8'($urandom), $urandom_range(0, 3) != 0);
    join
    drain("rx_pending", 2000);

    rx_frame(8'hC3, 1'b1);
    rx_frame(8'h5A, 1'b0);
    check_eq("frm_err_rdy", resp_rdy, 0);
    check_eq("frm_err_resp", resp, model_resp);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * B) @(negedge clk);
    check_eq("glitch_rdy", resp_rdy, 0);
    check_eq("glitch_resp", resp, model_resp);
    drain("rx2_pending", 2000);

`ifdef RESP_TIMEOUT_EN
    send_cmd(16'($urandom));
    check_eq("tmo_clr_on_send", resp_tmo, 0);
    wait_snt(t0);
    begin
      int k = 0;
      while (resp_tmo !== 1'b1 && k < 3 * T) begin
        @(negedge clk);
        k++;
      end
    end
    check_rng("tmo_delay", cyc - t0, T - 1, T + 1);

    send_cmd(16'($urandom));
    check_eq("tmo_clr2", resp_tmo, 0);
    wait_snt(t0);
    rx_frame(8'h3E, 1'b1);
    seen = 1'b0;
    repeat (T + 200) begin
      @(negedge clk);
      if (resp_tmo === 1'b1) seen = 1'b1;
    end
    check_eq("tmo_with_reply", seen, 0);
    drain("tmo_pending", 2000);
`endif

    // Reset in the middle of a TX frame forces the line idle immediately.
    send_cmd(16'hFFFF ^ 16'($urandom_range(1, 255)));
    repeat (40) @(negedge clk);
    check_eq("tx_busy_before_rst", tx_st != 2'd0, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_tx", TX, 1);
    check_eq("midrst_cmd_snt", cmd_snt, 0);
    check_eq("midrst_resp_rdy", resp_rdy, 0);
    check_eq("midrst_resp", resp, 0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
